// File: rtl/capture_pkg.sv
// Shared types and default sizing for the scope capture sequencer.
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ARMED,
    POST,
    DONE
  } cap_state_t;

  localparam int DEF_ENTRIES       = 512;
  localparam int DEF_TIMEOUT_SMPLS = 4096;

endpackage

// File: rtl/circ_addr_cnt.sv
// AW-bit wrapping address counter; clr has priority over inc.
module circ_addr_cnt #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] cnt
);

  logic [AW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/capture_ctrl.sv
// Scope capture sequencer: pre-fill, arm, trigger, post-fill of a circular sample RAM.
// Optional forced trigger after TIMEOUT_SMPLS armed samples when TRIG_TIMEOUT_EN is defined.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int ENTRIES       = DEF_ENTRIES,
  parameter int AW            = $clog2(ENTRIES),
  parameter int TIMEOUT_SMPLS = DEF_TIMEOUT_SMPLS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [AW-1:0] trig_pos,
  input  logic          smpl_en,
  input  logic          triggered,
  output logic          armed,
  output logic          set_capture_done,
  output logic          capture_done,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] trig_addr,
  output logic [AW-1:0] rd_start,
  output logic          timed_out
);

  if (ENTRIES < 4 || (ENTRIES & (ENTRIES - 1)) != 0 || TIMEOUT_SMPLS < 1) begin : g_param_check
    $error("capture_ctrl: ENTRIES must be a power of 2 >= 4 and TIMEOUT_SMPLS >= 1");
  end

  cap_state_t    state_reg, state_next;
  logic [AW-1:0] tp_reg, tp_next;
  logic [AW:0]   smpl_cnt_reg, smpl_cnt_next;
  logic [AW:0]   post_cnt_reg, post_cnt_next;
  logic [AW-1:0] trig_addr_reg, trig_addr_next;
  logic [AW-1:0] rd_start_reg, rd_start_next;
  logic          timed_out_reg, timed_out_next;
  logic          armed_reg, set_capture_done_reg, capture_done_reg;
  logic [AW:0]   pre_target;
  logic          accept, forced, fire, pre_done, post_done;

  assign accept     = run && (state_reg == IDLE || state_reg == DONE);
  assign we         = smpl_en && (state_reg == PRE || state_reg == ARMED || state_reg == POST);
  assign pre_target = (AW + 1)'(ENTRIES) - {1'b0, tp_reg};
  assign pre_done   = we && ((smpl_cnt_reg + 1'b1) == pre_target);
  assign post_done  = we && ((post_cnt_reg + 1'b1) == {1'b0, tp_reg});
  assign fire       = triggered || forced;

`ifdef TRIG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_SMPLS + 1);
  logic [TW-1:0] to_cnt_reg;

  // Counts every strobe spent waiting in ARMED; restarts whenever ARMED is left.
  always_ff @(posedge clk) begin
    if (rst || state_reg != ARMED) begin
      to_cnt_reg <= '0;
    end else if (smpl_en) begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end

  assign forced = (state_reg == ARMED) && smpl_en && ((to_cnt_reg + 1'b1) == TW'(TIMEOUT_SMPLS));
`else
  assign forced = 1'b0;
`endif

  circ_addr_cnt #(
    .AW (AW)
  ) u_waddr (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .inc (we),
    .cnt (waddr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg            <= IDLE;
      tp_reg               <= '0;
      smpl_cnt_reg         <= '0;
      post_cnt_reg         <= '0;
      trig_addr_reg        <= '0;
      rd_start_reg         <= '0;
      timed_out_reg        <= 1'b0;
      armed_reg            <= 1'b0;
      set_capture_done_reg <= 1'b0;
      capture_done_reg     <= 1'b0;
    end else begin
      state_reg            <= state_next;
      tp_reg               <= tp_next;
      smpl_cnt_reg         <= smpl_cnt_next;
      post_cnt_reg         <= post_cnt_next;
      trig_addr_reg        <= trig_addr_next;
      rd_start_reg         <= rd_start_next;
      timed_out_reg        <= timed_out_next;
      armed_reg            <= (state_next == ARMED);
      set_capture_done_reg <= (state_next == DONE) && (state_reg != DONE);
      capture_done_reg     <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (run)       state_next = PRE;
      PRE:        if (pre_done)  state_next = ARMED;
      ARMED:      if (fire)      state_next = POST;
      POST:       if (post_done) state_next = DONE;
      default:                   state_next = IDLE;
    endcase
  end

  always_comb begin
    tp_next        = tp_reg;
    smpl_cnt_next  = smpl_cnt_reg;
    post_cnt_next  = post_cnt_reg;
    trig_addr_next = trig_addr_reg;
    rd_start_next  = rd_start_reg;
    timed_out_next = timed_out_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (run) begin
          tp_next        = (trig_pos == '0) ? AW'(1) : trig_pos;
          smpl_cnt_next  = '0;
          post_cnt_next  = '0;
          timed_out_next = 1'b0;
        end
      end
      PRE: begin
        if (we) smpl_cnt_next = smpl_cnt_reg + 1'b1;
      end
      ARMED: begin
        // A sample written in the trigger cycle still belongs to the pre-trigger side.
        if (fire) begin
          trig_addr_next = waddr + AW'(we);
          post_cnt_next  = '0;
          if (forced && !triggered) timed_out_next = 1'b1;
        end
      end
      POST: begin
        if (we) begin
          post_cnt_next = post_cnt_reg + 1'b1;
          if (post_done) rd_start_next = waddr + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign armed            = armed_reg;
  assign set_capture_done = set_capture_done_reg;
  assign capture_done     = capture_done_reg;
  assign trig_addr        = trig_addr_reg;
  assign rd_start         = rd_start_reg;
  assign timed_out        = timed_out_reg;

endmodule
